// File: rtl/seq_word_serializer_if.sv
// Handshake and serial-output bundle for the word serializer that feeds the sequence detector.
interface seq_word_serializer_if #(
    parameter int W     = 4,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  in_word;
    logic          in_valid;
    logic          in_ready;
    logic          en;
    logic          out;
    logic          out_valid;
    logic          frame_start;
    logic          frame_end;
    logic [CW-1:0] fifo_count;
    logic          busy;

    modport master (
        output in_word, in_valid, en,
        input  in_ready, out, out_valid, frame_start, frame_end, fifo_count, busy
    );

    modport slave (
        input  in_word, in_valid, en,
        output in_ready, out, out_valid, frame_start, frame_end, fifo_count, busy
    );
endinterface

// File: rtl/seq_word_serializer.sv
// Buffers parallel pattern words in a small FIFO and shifts them out MSB-first,
// back-to-back, with frame markers for the downstream sequence detector.
module seq_word_serializer #(
    parameter int   W        = 4,
    parameter int   DEPTH    = 4,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    seq_word_serializer_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = (W > 1) ? $clog2(W) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic [0:0]    state;
    logic [W-1:0]  sr;
    logic [BW-1:0] bit_cnt;
    logic          out_q, ov_q, fs_q, fe_q;

    logic          full, push, pop, shift;
    logic [W-1:0]  head, sr_nx;

    // in_ready ignores a same-cycle pop, so a full FIFO never takes a push.
    assign full         = (count == CW'(DEPTH));
    assign bus.in_ready = !rst && !full;
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = bus.en && (count != '0) && (state == IDLE || bit_cnt == '0);
    assign shift        = bus.en && (state == SHIFT) && (bit_cnt != '0);
    assign head         = mem[rd_ptr];
    assign sr_nx        = sr << 1;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.in_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sr      <= '0;
            bit_cnt <= '0;
            out_q   <= IDLE_BIT;
            ov_q    <= 1'b0;
            fs_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else if (pop) begin
            state   <= SHIFT;
            sr      <= head;
            bit_cnt <= BW'(W - 1);
            out_q   <= head[W-1];
            ov_q    <= 1'b1;
            fs_q    <= 1'b1;
            fe_q    <= (W == 1);
        end else if (shift) begin
            sr      <= sr_nx;
            bit_cnt <= bit_cnt - BW'(1);
            out_q   <= sr_nx[W-1];
            fs_q    <= 1'b0;
            fe_q    <= (bit_cnt == BW'(1));
        end else if (bus.en && state == SHIFT) begin
            // Last bit done and nothing queued: fall back to idle.
            state   <= IDLE;
            out_q   <= IDLE_BIT;
            ov_q    <= 1'b0;
            fs_q    <= 1'b0;
            fe_q    <= 1'b0;
        end
    end

    assign bus.out         = out_q;
    assign bus.out_valid   = ov_q;
    assign bus.frame_start = fs_q;
    assign bus.frame_end   = fe_q;
    assign bus.fifo_count  = count;
    assign bus.busy        = (state == SHIFT);
endmodule

// File: tb/tb_seq_word_serializer.sv
// Self-checking bench for seq_word_serializer: constant vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_seq_word_serializer;
    localparam int W     = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seq_word_serializer_if #(.W(W), .DEPTH(DEPTH)) sif();

    seq_word_serializer #(.W(W), .DEPTH(DEPTH), .IDLE_BIT(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a word queue plus the word on the wire and how many of its bits remain.
    logic [W-1:0] mq[$];
    logic [W-1:0] pushed[$];
    logic [W-1:0] mcur;
    int           mrem;
    logic         last_acc;

    typedef struct packed {
        logic       r;
        logic       v;
        logic [3:0] w;
        logic       e;
        logic       o, ov, fs, fe, b, rdy;
        logic [2:0] cnt;
    } vec_t;

    vec_t tbl [15];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    task automatic model_reset();
        mq.delete();
        pushed.delete();
        mcur     = '0;
        mrem     = 0;
        last_acc = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [W-1:0] w, input logic e);
        int sz;
        sz = mq.size();
        if (e) begin
            if (mrem > 1) mrem--;
            else if (sz > 0) begin
                mcur = mq.pop_front();
                mrem = W;
            end else mrem = 0;
        end
        last_acc = v && (sz < DEPTH);
        if (last_acc) begin
            mq.push_back(w);
            pushed.push_back(w);
        end
    endtask

    task automatic cmp_model();
        chk("m.out",   sif.out,         (mrem > 0) ? mcur[mrem-1] : 1'b0);
        chk("m.ov",    sif.out_valid,   mrem > 0);
        chk("m.fs",    sif.frame_start, mrem == W);
        chk("m.fe",    sif.frame_end,   mrem == 1);
        chk("m.busy",  sif.busy,        mrem > 0);
        chk("m.count", sif.fifo_count,  mq.size());
        chk("m.ready", sif.in_ready,    mq.size() < DEPTH);
    endtask

    task automatic step(input logic v, input logic [W-1:0] w, input logic e);
        sif.in_valid = v;
        sif.in_word  = w;
        sif.en       = e;
        @(posedge clk);
        model_edge(v, w, e);
        @(negedge clk);
        cmp_model();
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        sif.in_valid = 1'b0;
        sif.in_word  = '0;
        sif.en       = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst.out",   sif.out,        0);
        chk("rst.ov",    sif.out_valid,  0);
        chk("rst.busy",  sif.busy,       0);
        chk("rst.count", sif.fifo_count, 0);
        chk("rst.ready", sif.in_ready,   0);
        rst = 1'b0;
    endtask

    initial begin
        logic [23:0]  sbits;
        int           nb, gaps, idx, cyc, bad;
        logic [W-1:0] words [6];
        logic         bitsq[$];
        logic         expq[$];
        logic [W-1:0] wtmp;

        sif.in_valid = 1'b0;
        sif.in_word  = '0;
        sif.en       = 1'b0;

        // Single word then a filled FIFO, as constant expectations.
        tbl[0]  = '{1'b1, 1'b1, 4'b1101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
        tbl[1]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0};
        tbl[2]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0};
        tbl[3]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0};
        tbl[4]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0};
        tbl[5]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};
        tbl[6]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};
        tbl[7]  = '{1'b1, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
        tbl[8]  = '{1'b0, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2};
        tbl[9]  = '{1'b0, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3};
        tbl[10] = '{1'b0, 1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4};
        tbl[11] = '{1'b0, 1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4};
        tbl[12] = '{1'b0, 1'b1, 4'b0101, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3};
        tbl[13] = '{1'b0, 1'b1, 4'b0101, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4};
        tbl[14] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4};

        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].r) do_reset();
            step(tbl[i].v, tbl[i].w, tbl[i].e);
            chk($sformatf("t%0d.out", i),   sif.out,         tbl[i].o);
            chk($sformatf("t%0d.ov", i),    sif.out_valid,   tbl[i].ov);
            chk($sformatf("t%0d.fs", i),    sif.frame_start, tbl[i].fs);
            chk($sformatf("t%0d.fe", i),    sif.frame_end,   tbl[i].fe);
            chk($sformatf("t%0d.busy", i),  sif.busy,        tbl[i].b);
            chk($sformatf("t%0d.ready", i), sif.in_ready,    tbl[i].rdy);
            chk($sformatf("t%0d.count", i), sif.fifo_count,  tbl[i].cnt);
        end

        // Back-to-back stream of six words, pushed as fast as in_ready allows.
        do_reset();
        words[0] = 4'b1101; words[1] = 4'b0010; words[2] = 4'b1001;
        words[3] = 4'b1101; words[4] = 4'b1110; words[5] = 4'b1101;
        sbits = '0; nb = 0; gaps = 0; idx = 0; cyc = 0;
        while (cyc < 80 && (idx < 6 || mrem > 0 || mq.size() > 0)) begin
            step(idx < 6, (idx < 6) ? words[idx] : 4'b0000, 1'b1);
            if (last_acc) idx++;
            if (sif.out_valid && nb < 24) begin
                sbits = {sbits[22:0], sif.out};
                nb++;
            end else if (nb > 0 && nb < 24) gaps++;
            cyc++;
        end
        chk("stream.timeout", cyc < 80, 1);
        chk("stream.pushed",  idx, 6);
        chk("stream.nbits",   nb, 24);
        chk("stream.gaps",    gaps, 0);
        chk("stream.bits",    sbits, 24'b1101_0010_1001_1101_1110_1101);

        // Stall for three cycles after the second bit of 1110, pushing during the stall.
        do_reset();
        step(1'b1, 4'b1110, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(i == 0, 4'b0101, 1'b0);
            chk($sformatf("stall%0d.out", i),   sif.out,         1);
            chk($sformatf("stall%0d.fs", i),    sif.frame_start, 0);
            chk($sformatf("stall%0d.fe", i),    sif.frame_end,   0);
            chk($sformatf("stall%0d.count", i), sif.fifo_count,  1);
        end
        step(1'b0, 4'b0000, 1'b1);
        chk("resume.b1", sif.out, 1);
        step(1'b0, 4'b0000, 1'b1);
        chk("resume.b0", sif.out, 0);
        chk("resume.fe", sif.frame_end, 1);
        step(1'b0, 4'b0000, 1'b1);
        chk("resume.next_fs", sif.frame_start, 1);
        chk("resume.next_msb", sif.out, 0);

        // Asynchronous reset mid-word with two words still queued.
        do_reset();
        step(1'b1, 4'b0010, 1'b0);
        step(1'b1, 4'b1101, 1'b0);
        step(1'b1, 4'b1001, 1'b0);
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        chk("pre_rst.out", sif.out, 1);
        sif.en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst.out",   sif.out,        0);
        chk("arst.ov",    sif.out_valid,  0);
        chk("arst.count", sif.fifo_count, 0);
        chk("arst.busy",  sif.busy,       0);
        chk("arst.ready", sif.in_ready,   0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 4'b0000, 1'b1);
            chk($sformatf("post_rst%0d.ov", i), sif.out_valid, 0);
        end

        // Randomized pushes and enables across several pointer wraps.
        do_reset();
        idx = 0; cyc = 0;
        bitsq.delete();
        while (cyc < 2000 && (idx < 10 || mrem > 0 || mq.size() > 0)) begin
            logic v, e;
            v    = (idx < 10) && ($urandom_range(0, 1) == 1);
            e    = ($urandom_range(0, 3) != 0);
            wtmp = W'($urandom);
            step(v, wtmp, e);
            if (last_acc) idx++;
            if (e && sif.out_valid) bitsq.push_back(sif.out);
            cyc++;
        end
        chk("rand.timeout", cyc < 2000, 1);
        expq.delete();
        foreach (pushed[k])
            for (int b = W - 1; b >= 0; b--) begin
                wtmp = pushed[k];
                expq.push_back(wtmp[b]);
            end
        chk("rand.nbits", bitsq.size(), expq.size());
        bad = 0;
        foreach (expq[k])
            if (k < bitsq.size() && bitsq[k] !== expq[k]) bad++;
        chk("rand.bit_errors", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
